// File: rtl/bound_up_down_remove_if.sv
// Video stream bundle for the row-strip stage: raster input with syncs, cropped raster output
// plus per-line / per-frame status pulses.
interface bound_up_down_remove_if #(
  parameter int DW = 8
);
  logic          din_vsync;
  logic          din_hsync;
  logic [DW-1:0] din;
  logic          dout_vsync;
  logic          dout_hsync;
  logic [DW-1:0] dout;
  logic          err_line;
  logic          err_frame;
  logic          frame_done;

  modport master (
    output din_vsync, din_hsync, din,
    input  dout_vsync, dout_hsync, dout, err_line, err_frame, frame_done
  );

  modport slave (
    input  din_vsync, din_hsync, din,
    output dout_vsync, dout_hsync, dout, err_line, err_frame, frame_done
  );
endinterface

// File: rtl/bound_up_down_remove.sv
// Strips the R replicated rows added above and below each frame for the KSZ-tap window,
// forwarding only the IH original rows and flagging malformed lines and frames.
module bound_up_down_remove #(
  parameter int KSZ = 5,
  parameter int DW  = 8,
  parameter int IW  = 4,
  parameter int IH  = 2,
  parameter int CW  = 12
) (
  input logic                  clk,
  input logic                  rst,
  bound_up_down_remove_if.slave bus
);
  localparam int R = (KSZ - 1) / 2;
  localparam logic [CW-1:0] ROW_LO   = CW'(R);
  localparam logic [CW-1:0] ROW_HI   = CW'(R + IH - 1);
  localparam logic [CW-1:0] ROW_TOT  = CW'(IH + 2 * R);
  localparam logic [CW-1:0] LINE_LEN = CW'(IW);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  logic          vs_p1, hs_p1;
  logic          low_seen;
  logic          armed;
  logic [CW-1:0] row_cnt, col_cnt;
  logic          line_ok, line_keep;

  logic          vs_rise, vs_fall, hs_rise, hs_fall;
  logic [CW-1:0] row_eff, row_next;
  logic          ok_now, keep_now, fwd;
  logic [DW-1:0] pix;

  // Stage p0: edge detection and keep-window decision for the current input cycle.
  // low_seen blocks a false rising edge when reset releases in the middle of a frame.
  always_comb begin
    vs_rise  = bus.din_vsync & ~vs_p1 & low_seen;
    vs_fall  = ~bus.din_vsync & vs_p1;
    hs_rise  = bus.din_hsync & ~hs_p1;
    hs_fall  = ~bus.din_hsync & hs_p1;
    row_eff  = vs_rise ? '0 : row_cnt;
    ok_now   = hs_rise ? ((armed | vs_rise) & bus.din_vsync) : line_ok;
    keep_now = hs_rise ? (ok_now & (row_eff >= ROW_LO) & (row_eff <= ROW_HI)) : line_keep;
    // A line ending together with vsync is counted before the frame check.
    row_next = row_eff;
    if (hs_fall && line_ok && armed && !vs_rise) row_next = sat_inc(row_cnt);
    fwd = bus.din_hsync & keep_now;
    pix = fwd ? bus.din : '0;
  end

  // Stage p1: registered state and outputs, one cycle behind the input.
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_p1          <= 1'b0;
      hs_p1          <= 1'b0;
      low_seen       <= 1'b0;
      armed          <= 1'b0;
      row_cnt        <= '0;
      col_cnt        <= '0;
      line_ok        <= 1'b0;
      line_keep      <= 1'b0;
      bus.dout_vsync <= 1'b0;
      bus.dout_hsync <= 1'b0;
      bus.dout       <= '0;
      bus.err_line   <= 1'b0;
      bus.err_frame  <= 1'b0;
      bus.frame_done <= 1'b0;
    end else begin
      vs_p1    <= bus.din_vsync;
      hs_p1    <= bus.din_hsync;
      low_seen <= low_seen | ~bus.din_vsync;
      if (vs_fall)      armed <= 1'b0;
      else if (vs_rise) armed <= 1'b1;
      row_cnt <= row_next;
      if (hs_rise)            col_cnt <= CW'(1);
      else if (bus.din_hsync) col_cnt <= sat_inc(col_cnt);
      if (hs_rise) begin
        line_ok   <= ok_now;
        line_keep <= keep_now;
      end
      bus.dout_vsync <= bus.din_vsync;
      bus.dout_hsync <= fwd;
      bus.dout       <= pix;
      bus.err_line   <= hs_fall & (~line_ok | (col_cnt != LINE_LEN));
      bus.err_frame  <= vs_fall & armed & (row_next != ROW_TOT);
      bus.frame_done <= vs_fall;
    end
  end
endmodule

// File: tb/tb_bound_up_down_remove.sv
// Bench for bound_up_down_remove: builds a stimulus timeline, derives expected outputs from
// a line/frame level model, then compares every cycle and pins key scenarios to literals.
module tb_bound_up_down_remove;
  localparam int KSZ = 5, DW = 8, IW = 4, IH = 2, CW = 12;
  localparam int R = (KSZ - 1) / 2;
  localparam int N = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bound_up_down_remove_if #(.DW(DW)) bus ();

  bound_up_down_remove #(.KSZ(KSZ), .DW(DW), .IW(IW), .IH(IH), .CW(CW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic        s_rst [N];
  logic        s_vs  [N];
  logic        s_hs  [N];
  logic [7:0]  s_d   [N];
  logic [12:0] e_out [N];
  logic [12:0] a_out [N];
  int n = 0;
  int checks = 0;
  int errors = 0;

  task automatic put(input logic r, input logic v, input logic h, input logic [7:0] d);
    if (n < N) begin
      s_rst[n] = r; s_vs[n] = v; s_hs[n] = h; s_d[n] = d;
      n++;
    end
  endtask

  task automatic idle(input int c);
    repeat (c) put(1'b0, 1'b0, 1'b0, 8'd0);
  endtask

  // One frame: fp porch cycles, lines separated by gaps, bp cycles after the last line.
  task automatic frame(input int lines, input int fp, input int bp, input int short_ln,
                       input int rst_ln, input bit rnd);
    int len;
    logic [7:0] px;
    logic r;
    repeat (fp) put(1'b0, 1'b1, 1'b0, 8'd0);
    for (int k = 0; k < lines; k++) begin
      len = rnd ? int'($urandom_range(3, 5)) : ((k == short_ln) ? 3 : IW);
      for (int i = 0; i < len; i++) begin
        px = rnd ? 8'($urandom) : ((k == short_ln) ? 8'(11 + i) : 8'(k * 10 + i + 1));
        r  = (k == rst_ln) && (i == 1 || i == 2);
        put(r, 1'b1, 1'b1, px);
      end
      if (k < lines - 1) repeat (rnd ? $urandom_range(1, 3) : 2) put(1'b0, 1'b1, 1'b0, 8'd0);
      else repeat (bp) put(1'b0, 1'b1, 1'b0, 8'd0);
    end
  endtask

  // Reference: walk the timeline as lines (hsync runs) inside frames (vsync runs).
  task automatic build_model();
    bit armed, in_line, lok, prev_ok;
    int rows, la, lrow;
    logic vs_o, hs_o, el, ef, fd;
    logic [7:0] d_o;
    armed = 0; in_line = 0; lok = 0; rows = 0; la = 0; lrow = 0;
    for (int t = 0; t < n; t++) begin
      vs_o = 0; hs_o = 0; d_o = 8'd0; el = 0; ef = 0; fd = 0;
      if (s_rst[t]) begin
        armed = 0; in_line = 0;
      end else begin
        vs_o = s_vs[t];
        prev_ok = (t > 0) && !s_rst[t-1];
        if (prev_ok && s_vs[t] && !s_vs[t-1]) begin armed = 1; rows = 0; end
        if (s_hs[t] && !in_line) begin
          in_line = 1; la = t; lok = armed && s_vs[t]; lrow = rows;
        end
        if (in_line && !s_hs[t]) begin
          in_line = 0;
          el = !lok || ((t - la) != IW);
          if (lok && armed) rows++;
        end
        if (prev_ok && !s_vs[t] && s_vs[t-1]) begin
          fd = 1; ef = armed && (rows != IH + 2 * R); armed = 0;
        end
        if (in_line && lok && lrow >= R && lrow <= R + IH - 1) begin
          hs_o = 1; d_o = s_d[t];
        end
      end
      e_out[t] = {vs_o, hs_o, d_o, el, ef, fd};
    end
  endtask

  function automatic int cnt(input int lo, input int hi, input int b);
    int c = 0;
    for (int t = lo; t < hi; t++) c += int'(a_out[t][b]);
    return c;
  endfunction

  task automatic pin(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, got, want);
    end
  endtask

  int s1, s2, s3, s4, s5;
  logic [12:0] got;
  int lit [8] = '{21, 22, 23, 24, 31, 32, 33, 34};
  int q [$];

  initial begin
    bus.din_vsync = 1'b0; bus.din_hsync = 1'b0; bus.din = '0;
    repeat (3) put(1'b1, 1'b0, 1'b0, 8'd0);
    idle(3);
    frame(6, 2, 2, -1, -1, 0); idle(4); s1 = n;
    frame(5, 2, 2, -1, -1, 0); idle(4);
    frame(6, 2, 2, -1, -1, 0); idle(4); s2 = n;
    frame(6, 2, 2, 2, -1, 0);  idle(4); s3 = n;
    for (int i = 0; i < 4; i++) put(1'b0, 1'b0, 1'b1, 8'(50 + i));
    idle(3);
    frame(6, 2, 2, -1, -1, 0); idle(4); s4 = n;
    frame(6, 2, 2, -1, 2, 0);  idle(4);
    frame(6, 2, 2, -1, -1, 0); idle(4); s5 = n;
    frame(6, 1, 0, -1, -1, 0); idle(4);
    frame(8, 2, 1, -1, -1, 0); idle(4);
    repeat (12) begin
      frame(int'($urandom_range(4, 8)), int'($urandom_range(1, 3)), int'($urandom_range(0, 2)),
            -1, -1, 1);
      idle(int'($urandom_range(2, 4)));
    end
    build_model();

    for (int t = 0; t < n; t++) begin
      @(negedge clk);
      rst = s_rst[t];
      bus.din_vsync = s_vs[t];
      bus.din_hsync = s_hs[t];
      bus.din       = s_d[t];
      @(posedge clk);
      #1;
      got = {bus.dout_vsync, bus.dout_hsync, bus.dout, bus.err_line, bus.err_frame, bus.frame_done};
      a_out[t] = got;
      checks++;
      if (got !== e_out[t]) begin
        errors++;
        $display("FAIL cycle %0d outputs {vs,hs,dout,el,ef,fd} got=%b expected=%b", t, got, e_out[t]);
      end
    end

    pin("reset_outputs_zero", int'(a_out[2]), 0);
    for (int t = 0; t < s1; t++) if (a_out[t][11]) q.push_back(int'(a_out[t][10:3]));
    pin("s1_kept_pixel_count", q.size(), 8);
    for (int i = 0; i < 8 && i < q.size(); i++) pin($sformatf("s1_pixel_%0d", i), q[i], lit[i]);
    pin("s1_frame_done", cnt(0, s1, 0), 1);
    pin("s1_err_frame", cnt(0, s1, 1), 0);
    pin("s1_err_line", cnt(0, s1, 2), 0);
    pin("s2_err_frame", cnt(s1, s2, 1), 1);
    pin("s2_kept_cycles", cnt(s1, s2, 11), 16);
    pin("s3_err_line", cnt(s2, s3, 2), 1);
    pin("s3_kept_cycles", cnt(s2, s3, 11), 7);
    pin("s4_err_line", cnt(s3, s4, 2), 1);
    pin("s4_kept_cycles", cnt(s3, s4, 11), 8);
    pin("s5_err_frame", cnt(s4, s5, 1), 0);
    pin("s5_kept_cycles", cnt(s4, s5, 11), 9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
